// File: rtl/adc_sample_sequencer.sv
// Periodic MCP3002-style SPI ADC sequencer: sample-period tick, frame FSM with
// registered SPI pins, one-cycle sample strobe and a dropped-tick overrun pulse.
module adc_sample_sequencer #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int DATA_BITS     = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 channel,
    input  logic                 dinAdc,
    output logic                 sclkAdc,
    output logic                 doutAdc,
    output logic                 ncsAdc,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 overrun
);

    localparam int FRAME = 5 + DATA_BITS;
    localparam int PW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW    = $clog2(FRAME + 1);

    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(FRAME - 1);
    localparam logic [BW-1:0] FIRST_DATA  = BW'(5);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_n;
    logic [PW-1:0]         period_cnt;
    logic                  tick;
    logic [DW-1:0]         div_q, div_n;
    logic                  div_last;
    logic [BW-1:0]         bit_q, bit_n, bit_inc;
    logic                  chan_q, chan_n;
    logic [DATA_BITS-1:0]  shreg_q, shreg_n;
    logic                  sclk_n, dout_n, ncs_n;
    logic [DATA_BITS-1:0]  sample_n;
    logic                  valid_n, ovr_n;

    // Command word b0..b3 = start, single-ended, channel, MSB-first; b4 and data bits drive 0.
    function automatic logic cmd_bit(input logic [BW-1:0] b, input logic ch);
        case (int'(b))
            0, 1, 3: cmd_bit = 1'b1;
            2:       cmd_bit = ch;
            default: cmd_bit = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (!enable || period_cnt == PERIOD_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    assign tick     = enable && (period_cnt == PERIOD_LAST);
    assign div_last = (div_q == DIV_LAST);
    assign bit_inc  = bit_q + 1'b1;

    always_comb begin
        state_n  = state_q;
        div_n    = div_q;
        bit_n    = bit_q;
        chan_n   = chan_q;
        shreg_n  = shreg_q;
        sclk_n   = sclkAdc;
        dout_n   = doutAdc;
        ncs_n    = ncsAdc;
        sample_n = sample;
        valid_n  = 1'b0;
        ovr_n    = tick && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                ncs_n  = 1'b1;
                sclk_n = 1'b0;
                dout_n = 1'b0;
                if (tick) begin
                    state_n = SETUP;
                    chan_n  = channel;
                    div_n   = '0;
                    bit_n   = '0;
                    ncs_n   = 1'b0;
                    dout_n  = cmd_bit('0, channel);
                end
            end
            SETUP: begin
                // Last SETUP cycle doubles as the low phase ahead of bit 0.
                if (div_last) begin
                    state_n = SHIFT;
                    div_n   = '0;
                    sclk_n  = 1'b1;
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (!div_last) begin
                    div_n = div_q + 1'b1;
                end else if (sclkAdc) begin
                    sclk_n = 1'b0;
                    div_n  = '0;
                    dout_n = cmd_bit(bit_inc, chan_q);
                end else if (bit_q == BIT_LAST) begin
                    state_n  = DONE;
                    div_n    = '0;
                    ncs_n    = 1'b1;
                    dout_n   = 1'b0;
                    sample_n = shreg_q;
                    valid_n  = 1'b1;
                end else begin
                    // Rising edge of bit b+1: capture what the ADC presents for it.
                    sclk_n = 1'b1;
                    div_n  = '0;
                    bit_n  = bit_inc;
                    if (bit_inc >= FIRST_DATA) begin
                        shreg_n = {shreg_q[DATA_BITS-2:0], dinAdc};
                    end
                end
            end
            DONE: begin
                if (div_last) begin
                    state_n = IDLE;
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            chan_q       <= 1'b0;
            shreg_q      <= '0;
            sclkAdc      <= 1'b0;
            doutAdc      <= 1'b0;
            ncsAdc       <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_n;
            div_q        <= div_n;
            bit_q        <= bit_n;
            chan_q       <= chan_n;
            shreg_q      <= shreg_n;
            sclkAdc      <= sclk_n;
            doutAdc      <= dout_n;
            ncsAdc       <= ncs_n;
            sample       <= sample_n;
            sample_valid <= valid_n;
            overrun      <= ovr_n;
        end
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench: a nominal-period instance fed by a bench SPI ADC model and a
// short-period instance whose ticks collide with busy frames.
module tb_adc_sample_sequencer;

    localparam int CD  = 2;
    localparam int SP  = 100;
    localparam int SP2 = 50;
    localparam int DB  = 10;

    typedef struct {
        logic [DB-1:0] val;
        int            cyc;
        logic [4:0]    cmd;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    logic          rst, en, ch, sclk, dout, ncs, vld, ovr;
    logic          din = 1'b0;
    logic [DB-1:0] smp;
    logic          rst2, en2, sclk2, dout2, ncs2, vld2, ovr2;
    logic          din2 = 1'b1;
    logic          ch2 = 1'b0;
    logic [DB-1:0] smp2;

    adc_sample_sequencer #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .DATA_BITS(DB)) u_dut (
        .clk(clk), .reset(rst), .enable(en), .channel(ch), .dinAdc(din),
        .sclkAdc(sclk), .doutAdc(dout), .ncsAdc(ncs),
        .sample(smp), .sample_valid(vld), .overrun(ovr)
    );

    adc_sample_sequencer #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP2), .DATA_BITS(DB)) u_dut_ovr (
        .clk(clk), .reset(rst2), .enable(en2), .channel(ch2), .dinAdc(din2),
        .sclkAdc(sclk2), .doutAdc(dout2), .ncsAdc(ncs2),
        .sample(smp2), .sample_valid(vld2), .overrun(ovr2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // ADC model for u_dut: records command bits at rising sclk, drives data after falling sclk.
    exp_t          exp_q[$];
    logic [DB-1:0] adc_q[$];
    logic [DB-1:0] cur_word = '0;
    logic [4:0]    cmd_cap = '0;
    int            rises = 0;
    int            bad_sclk = 0;
    logic          ncs_m = 1'b1;
    logic          sclk_m = 1'b0;

    always @(sclk or ncs) begin
        if (ncs_m === 1'b1 && ncs === 1'b0) begin
            rises   = 0;
            cmd_cap = '0;
            din     = 1'b0;
            cur_word = '0;
            if (adc_q.size() > 0) cur_word = adc_q.pop_front();
        end
        if (sclk_m === 1'b0 && sclk === 1'b1) begin
            if (!rst && ncs) bad_sclk++;
            if (rises < 5) cmd_cap[4 - rises] = dout;
            rises++;
        end
        if (sclk_m === 1'b1 && sclk === 1'b0) begin
            if (!rst && ncs) bad_sclk++;
            if (rises >= 5 && rises < 5 + DB) din = cur_word[DB - 1 - (rises - 5)];
            else din = 1'b0;
        end
        ncs_m  = ncs;
        sclk_m = sclk;
    end

    int   rises2 = 0;
    logic ncs2_m = 1'b1;
    logic sclk2_m = 1'b0;

    always @(sclk2 or ncs2) begin
        if (ncs2_m === 1'b1 && ncs2 === 1'b0) rises2 = 0;
        if (sclk2_m === 1'b0 && sclk2 === 1'b1) rises2++;
        ncs2_m  = ncs2;
        sclk2_m = sclk2;
    end

    // Monitor for u_dut
    exp_t e1;
    int   n_falls = 0;
    int   last_fall = -1;
    int   n_ovr = 0;
    logic vld_prev = 1'b0;
    logic ncs_prev = 1'b1;

    always @(negedge clk) begin
        if (vld === 1'b1) begin
            chk("valid_width", int'(vld_prev), 0);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid: sample 0x%0h at cycle %0d, none expected", smp, cyc);
            end else begin
                e1 = exp_q.pop_front();
                chk("sample", int'(smp), int'(e1.val));
                chk("valid_cycle", cyc, e1.cyc);
                chk("cmd_bits", int'(cmd_cap), int'(e1.cmd));
                chk("sclk_rises", rises, 5 + DB);
            end
        end
        if (ovr === 1'b1) n_ovr++;
        if (ncs_prev === 1'b1 && ncs === 1'b0) begin
            n_falls++;
            last_fall = cyc;
        end
        vld_prev = vld;
        ncs_prev = ncs;
    end

    // Monitor for u_dut_ovr
    int   exp2_q[$];
    int   ov2_q[$];
    logic vld2_prev = 1'b0;
    logic ovr2_prev = 1'b0;

    always @(negedge clk) begin
        if (vld2 === 1'b1) begin
            chk("valid2_width", int'(vld2_prev), 0);
            if (exp2_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid2: sample 0x%0h at cycle %0d, none expected", smp2, cyc);
            end else begin
                chk("valid2_cycle", cyc, exp2_q.pop_front());
                chk("sample2", int'(smp2), 'h3FF);
                chk("sclk2_rises", rises2, 5 + DB);
            end
        end
        if (ovr2 === 1'b1) begin
            chk("overrun2_width", int'(ovr2_prev), 0);
            if (ov2_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_overrun2 at cycle %0d, none expected", cyc);
            end else begin
                chk("overrun2_cycle", cyc, ov2_q.pop_front());
            end
        end
        vld2_prev = vld2;
        ovr2_prev = ovr2;
    end

    initial begin
        int r, e, r2, q;
        rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0; ch = 1'b0;

        wait_until(3);
        chk("rst_ncs", int'(ncs), 1);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_sample", int'(smp), 0);
        chk("rst_valid", int'(vld), 0);
        chk("rst_overrun", int'(ovr), 0);

        // Four back-to-back frames: ticks at r+99+100k, valid 63 cycles after each tick.
        r = cyc; rst = 1'b0; en = 1'b1;
        adc_q.push_back(10'h2A5); exp_q.push_back('{10'h2A5, r + 162, 5'b11010});
        adc_q.push_back(10'h3FF); exp_q.push_back('{10'h3FF, r + 262, 5'b11110});
        adc_q.push_back(10'h001); exp_q.push_back('{10'h001, r + 362, 5'b11010});
        adc_q.push_back(10'h155); exp_q.push_back('{10'h155, r + 462, 5'b11010});

        wait_until(r + 101); chk("first_fall_cycle", last_fall, r + 100);
        wait_until(r + 150); ch = 1'b1;
        wait_until(r + 219); ch = 1'b0;
        wait_until(r + 409); en = 1'b0;
        wait_until(r + 700); chk("falls_after_enable_drop", n_falls, 4);

        e = cyc; en = 1'b1;
        adc_q.push_back(10'h0AA);
        wait_until(e + 101); chk("reenable_fall_cycle", last_fall, e + 100);
        wait_until(e + 106);
        chk("mid_frame_sclk", int'(sclk), 1);
        chk("mid_frame_dout", int'(dout), 1);
        rst = 1'b1;
        #1;
        chk("abort_ncs", int'(ncs), 1);
        chk("abort_sclk", int'(sclk), 0);
        chk("abort_dout", int'(dout), 0);
        chk("abort_sample", int'(smp), 0);
        chk("abort_valid", int'(vld), 0);

        wait_until(e + 110);
        r2 = cyc; ch = 1'b1; rst = 1'b0;
        adc_q.push_back(10'h133); exp_q.push_back('{10'h133, r2 + 162, 5'b11110});
        wait_until(r2 + 101); chk("post_reset_fall_cycle", last_fall, r2 + 100);
        wait_until(r2 + 180); en = 1'b0;
        wait_until(r2 + 260);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("adc_words_consumed", adc_q.size(), 0);
        chk("overrun_pulses", n_ovr, 0);
        chk("sclk_while_ncs_high", bad_sclk, 0);

        // Short period: ticks at q+49+50k, odd ticks land in a busy frame.
        q = cyc; rst2 = 1'b0; en2 = 1'b1;
        exp2_q = '{q + 112, q + 212, q + 312};
        ov2_q  = '{q + 100, q + 200, q + 300};
        wait_until(q + 330); en2 = 1'b0;
        wait_until(q + 420);
        chk("scoreboard2_drained", exp2_q.size(), 0);
        chk("overrun2_drained", ov2_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
